// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports (inst fetch, load/store), the memory port and the grant owner.
// No logic: signal declarations and directions only.
// master = the arbiter's view; slave = the view of the environment (core ports plus memory model).
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // requester 0: instruction fetch (read-only)
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_err;
    logic [DATA_W-1:0] i_rdata;
    // requester 1: load/store
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;
    // single-port memory
    logic              m_req;
    logic              m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;
    // grant status
    logic              owner;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        output i_ready, i_err, i_rdata, d_ready, d_err, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata, owner
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        input  i_ready, i_err, i_rdata, d_ready, d_err, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between inst fetch (0) and load/store (1).
// Latency: grant -> m_req next cycle; m_ack -> ready pulse next cycle; 3 cycles minimum per access.
// Backpressure: requesters hold req until their ready pulse; memory stalls via m_ack, bounded by a watchdog.
// Ports: clk, reset (async, active high); bus (master modport) carries i_*, d_*, m_* and owner.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_arbiter_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Last WAIT count before abort; unused when the watchdog is disabled (TIMEOUT == 0).
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q,      owner_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              m_req_q,      m_req_d;
    logic              m_we_q,       m_we_d;
    logic [3:0]        m_be_q,       m_be_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
    logic              i_ready_q,    i_ready_d;
    logic              i_err_q,      i_err_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic              d_ready_q,    d_ready_d;
    logic              d_err_q,      d_err_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              grant_sel;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_be_d       = m_be_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        // ready/err are single-cycle pulses: low unless set on the way into DONE
        i_ready_d    = 1'b0;
        i_err_d      = 1'b0;
        d_ready_d    = 1'b0;
        d_err_d      = 1'b0;
        grant_sel    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_sel = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;
                    if (grant_sel) begin
                        m_we_d    = bus.d_we;
                        m_be_d    = bus.d_be;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_be_d    = 4'b1111;
                        m_addr_d  = bus.i_addr;
                        m_wdata_d = '0;
                    end
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    cnt_d        = '0;
                    m_req_d      = 1'b1;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    if (!m_we_q) begin
                        if (owner_q) d_rdata_d = bus.m_rdata;
                        else         i_rdata_d = bus.m_rdata;
                    end
                    if (owner_q) d_ready_d = 1'b1;
                    else         i_ready_d = 1'b1;
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // Watchdog abort: complete with error, read data left untouched.
                    m_req_d = 1'b0;
                    if (owner_q) begin
                        d_ready_d = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        i_ready_d = 1'b1;
                        i_err_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // Requests are deliberately ignored here so a requester can drop req after its ready.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_be_q       <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_ready_q    <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_be_q       <= m_be_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_ready_q    <= i_ready_d;
            i_err_q      <= i_err_d;
            i_rdata_q    <= i_rdata_d;
            d_ready_q    <= d_ready_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_be    = m_be_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.owner   = owner_q;
    assign bus.i_ready = i_ready_q;
    assign bus.i_err   = i_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Memory responses come from the bench, with random latency that sometimes exceeds the watchdog.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ack = 1'b0; bus.m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_be, bus.owner, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%0b we=%0b be=%h own=%0b ir=%0b ie=%0b dr=%0b de=%0b, want all 0",
                     bus.m_req, bus.m_we, bus.m_be, bus.owner, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err);
        end
        checks++;
        if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wd=%h ird=%h drd=%h, want 0",
                     bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
        end
    endtask

    task automatic test_inst_read();
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        step();
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_be, bus.owner} !== {1'b1, 1'b0, 4'hf, 1'b0} || bus.m_addr !== 32'h100) begin
            errors++;
            $display("FAIL inst_issue: got req=%0b we=%0b be=%h own=%0b addr=%h, want 1 0 f 0 00000100",
                     bus.m_req, bus.m_we, bus.m_be, bus.owner, bus.m_addr);
        end
        bus.m_ack = 1'b1; bus.m_rdata = 32'hE3A00001;
        step();
        checks++;
        if ({bus.i_ready, bus.i_err, bus.d_ready, bus.m_req} !== 4'b1000 || bus.i_rdata !== 32'hE3A00001) begin
            errors++;
            $display("FAIL inst_done: got ir=%0b ie=%0b dr=%0b mreq=%0b rd=%h, want 1 0 0 0 e3a00001",
                     bus.i_ready, bus.i_err, bus.d_ready, bus.m_req, bus.i_rdata);
        end
        bus.i_req = 1'b0; bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
        step();
        checks++;
        if ({bus.i_ready, bus.i_err, bus.m_req} !== 3'b000 || bus.i_rdata !== 32'hE3A00001) begin
            errors++;
            $display("FAIL inst_after: got ir=%0b ie=%0b mreq=%0b rd=%h, want 0 0 0 e3a00001",
                     bus.i_ready, bus.i_err, bus.m_req, bus.i_rdata);
        end
    endtask

    task automatic test_write_be();
        int pulses;
        do_reset();
        // preload d_rdata with a read so the write's "unchanged" check is meaningful
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hf; bus.d_addr = 32'h204;
        step();
        bus.m_ack = 1'b1; bus.m_rdata = 32'hA5A50F0F;
        step();
        bus.d_req = 1'b0; bus.m_ack = 1'b0;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
        step();
        for (int w = 0; w < 4; w++) begin
            checks++;
            if ({bus.m_req, bus.m_we, bus.m_be, bus.owner} !== {1'b1, 1'b1, 4'b0011, 1'b1} ||
                bus.m_addr !== 32'h200 || bus.m_wdata !== 32'h12345678 || bus.d_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_wait%0d: got req=%0b we=%0b be=%h own=%0b addr=%h wd=%h dr=%0b, want 1 1 3 1 00000200 12345678 0",
                         w, bus.m_req, bus.m_we, bus.m_be, bus.owner, bus.m_addr, bus.m_wdata, bus.d_ready);
            end
            if (w == 3) begin bus.m_ack = 1'b1; bus.m_rdata = 32'hDEADBEEF; end
            step();
        end
        pulses = (bus.d_ready === 1'b1) ? 1 : 0;
        checks++;
        if ({bus.d_ready, bus.d_err, bus.i_ready} !== 3'b100 || bus.d_rdata !== 32'hA5A50F0F) begin
            errors++;
            $display("FAIL write_done: got dr=%0b de=%0b ir=%0b drd=%h, want 1 0 0 a5a50f0f",
                     bus.d_ready, bus.d_err, bus.i_ready, bus.d_rdata);
        end
        bus.d_req = 1'b0; bus.m_ack = 1'b0;
        repeat (3) begin
            step();
            if (bus.d_ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL write_pulses: got %0d d_ready pulses, want 1", pulses);
        end
        // zero byte enables still issue an access
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0000; bus.d_addr = 32'h208; bus.d_wdata = 32'hCAFEF00D;
        step();
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_be} !== {1'b1, 1'b1, 4'b0000} || bus.m_addr !== 32'h208) begin
            errors++;
            $display("FAIL zero_be: got req=%0b we=%0b be=%h addr=%h, want 1 1 0 00000208",
                     bus.m_req, bus.m_we, bus.m_be, bus.m_addr);
        end
        bus.m_ack = 1'b1;
        step();
        bus.d_req = 1'b0; bus.m_ack = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hf; bus.d_addr = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            logic exp_own;
            int   t;
            exp_own = k[0];
            t = 0;
            step();
            while (bus.m_req !== 1'b1 && t < 10) begin step(); t++; end
            checks++;
            if (bus.m_req !== 1'b1 || bus.owner !== exp_own || bus.m_addr !== (exp_own ? 32'h2000 : 32'h1000)) begin
                errors++;
                $display("FAIL rr_grant%0d: got req=%0b own=%0b addr=%h, want 1 %0b %h",
                         k, bus.m_req, bus.owner, bus.m_addr, exp_own, exp_own ? 32'h2000 : 32'h1000);
            end
            bus.m_ack = 1'b1; bus.m_rdata = 32'h0;
            step();
            checks++;
            if ({bus.i_ready, bus.d_ready} !== (exp_own ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rr_ready%0d: got ir=%0b dr=%0b, want owner %0b only", k, bus.i_ready, bus.d_ready, exp_own);
            end
            if (exp_own) bus.d_req = 1'b0; else bus.i_req = 1'b0;
            bus.m_ack = 1'b0;
            step();
            bus.i_req = 1'b1; bus.d_req = 1'b1;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hf; bus.d_addr = 32'h300;
        step();
        bus.m_ack = 1'b1; bus.m_rdata = 32'h13572468;
        step();
        bus.d_req = 1'b0; bus.m_ack = 1'b0;
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h304;
        step();
        n = 0;
        while (bus.m_req === 1'b1 && n < 40) begin n++; step(); end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: got m_req high %0d cycles, want %0d", n, TIMEOUT);
        end
        checks++;
        if ({bus.d_ready, bus.d_err, bus.i_ready} !== 3'b110 || bus.d_rdata !== 32'h13572468) begin
            errors++;
            $display("FAIL timeout_done: got dr=%0b de=%0b ir=%0b drd=%h, want 1 1 0 13572468",
                     bus.d_ready, bus.d_err, bus.i_ready, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        step();
        checks++;
        if ({bus.d_ready, bus.d_err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got dr=%0b de=%0b, want 0 0", bus.d_ready, bus.d_err);
        end
        bus.d_req = 1'b1; bus.d_addr = 32'h308;
        step();
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0BADF00D;
        step();
        checks++;
        if ({bus.d_ready, bus.d_err} !== 2'b10 || bus.d_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL timeout_next: got dr=%0b de=%0b drd=%h, want 1 0 0badf00d", bus.d_ready, bus.d_err, bus.d_rdata);
        end
        bus.d_req = 1'b0; bus.m_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.m_req, bus.i_ready, bus.i_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: got mreq=%0b ir=%0b ie=%0b, want 0 0 0", bus.m_req, bus.i_ready, bus.i_err);
        end
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hf; bus.d_addr = 32'h500;
        step();
        checks++;
        if ({bus.m_req, bus.i_ready, bus.d_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_hold: got mreq=%0b ir=%0b dr=%0b, want 0 0 0", bus.m_req, bus.i_ready, bus.d_ready);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.m_req !== 1'b1 || bus.owner !== 1'b0 || bus.m_addr !== 32'h400) begin
            errors++;
            $display("FAIL rst_tie: got req=%0b own=%0b addr=%h, want 1 0 00000400", bus.m_req, bus.owner, bus.m_addr);
        end
        bus.m_ack = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_hold_req();
        int n;
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h600;
        step();
        bus.m_ack = 1'b1; bus.m_rdata = 32'h11112222;
        step();
        bus.m_ack = 1'b0;
        step();
        bus.i_req = 1'b0;
        n = 0;
        repeat (4) begin step(); if (bus.m_req === 1'b1) n++; end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL hold_done: got %0d cycles of m_req after drop, want 0", n);
        end
        bus.i_req = 1'b1;
        step();
        bus.m_ack = 1'b1;
        step();
        bus.m_ack = 1'b0;
        step();
        step();
        checks++;
        if (bus.m_req !== 1'b1 || bus.owner !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got req=%0b own=%0b, want 1 0", bus.m_req, bus.owner);
        end
        bus.m_ack = 1'b1;
        step();
        bus.i_req = 1'b0; bus.m_ack = 1'b0;
        step();
        n = 0;
        repeat (4) begin step(); if (bus.m_req === 1'b1) n++; end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL hold_once: got %0d extra m_req cycles, want 0", n);
        end
    endtask

    // Transaction model: phase 0 = arbiter free at the coming edge, 1 = access outstanding, 2 = completion cycle.
    task automatic test_random();
        int          phase, waits, lat;
        logic        last, cur, s_i, s_d, s_ack, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr, exp_wdata, exp_ird, exp_drd, s_rdata;
        do_reset();
        phase = 0; waits = 0; lat = 0; last = 1'b1; cur = 1'b0; exp_we = 1'b0; exp_be = '0;
        exp_addr = '0; exp_wdata = '0; exp_ird = '0; exp_drd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.i_req !== 1'b1 && $urandom_range(0, 2) == 0) begin
                bus.i_req = 1'b1; bus.i_addr = $urandom;
            end
            if (bus.d_req !== 1'b1 && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_be = 4'($urandom_range(0, 15));
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
            bus.m_ack = 1'b0;
            if ((phase == 1 && waits == lat) || (phase != 1 && $urandom_range(0, 5) == 0)) begin
                bus.m_ack = 1'b1; bus.m_rdata = $urandom;
            end
            s_i = bus.i_req; s_d = bus.d_req; s_ack = bus.m_ack && (phase == 1); s_rdata = bus.m_rdata;
            step();
            if (phase == 0) begin
                if (s_i || s_d) begin
                    cur       = (s_i && s_d) ? ~last : s_d;
                    last      = cur;
                    exp_addr  = cur ? bus.d_addr : bus.i_addr;
                    exp_we    = cur ? bus.d_we : 1'b0;
                    exp_be    = cur ? bus.d_be : 4'hf;
                    exp_wdata = cur ? bus.d_wdata : 32'h0;
                    checks++;
                    if ({bus.m_req, bus.owner, bus.m_we, bus.m_be} !== {1'b1, cur, exp_we, exp_be} ||
                        bus.m_addr !== exp_addr || bus.m_wdata !== exp_wdata) begin
                        errors++;
                        $display("FAIL rnd_grant cyc=%0d: got req=%0b own=%0b we=%0b be=%h addr=%h wd=%h, want 1 %0b %0b %h %h %h",
                                 cyc, bus.m_req, bus.owner, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata,
                                 cur, exp_we, exp_be, exp_addr, exp_wdata);
                    end
                    phase = 1; waits = 0; lat = $urandom_range(0, TIMEOUT + 3);
                end else begin
                    checks++;
                    if ({bus.m_req, bus.i_ready, bus.d_ready} !== 3'b000) begin
                        errors++;
                        $display("FAIL rnd_idle cyc=%0d: got mreq=%0b ir=%0b dr=%0b, want 0 0 0",
                                 cyc, bus.m_req, bus.i_ready, bus.d_ready);
                    end
                end
            end else if (phase == 1) begin
                if (s_ack || waits == TIMEOUT - 1) begin
                    if (s_ack && !exp_we) begin
                        if (cur) exp_drd = s_rdata; else exp_ird = s_rdata;
                    end
                    checks++;
                    if ({bus.m_req, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err} !==
                            {1'b0, !cur, !cur && !s_ack, cur, cur && !s_ack} ||
                        bus.i_rdata !== exp_ird || bus.d_rdata !== exp_drd) begin
                        errors++;
                        $display("FAIL rnd_done cyc=%0d: got mreq=%0b ir=%0b ie=%0b dr=%0b de=%0b ird=%h drd=%h, want own=%0b ack=%0b ird=%h drd=%h",
                                 cyc, bus.m_req, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err,
                                 bus.i_rdata, bus.d_rdata, cur, s_ack, exp_ird, exp_drd);
                    end
                    if (cur) bus.d_req = 1'b0; else bus.i_req = 1'b0;
                    phase = 2;
                end else begin
                    waits++;
                    checks++;
                    if ({bus.m_req, bus.owner, bus.m_we, bus.m_be, bus.i_ready, bus.d_ready} !== {1'b1, cur, exp_we, exp_be, 2'b00} ||
                        bus.m_addr !== exp_addr || bus.m_wdata !== exp_wdata) begin
                        errors++;
                        $display("FAIL rnd_wait cyc=%0d: got req=%0b own=%0b we=%0b be=%h addr=%h wd=%h ir=%0b dr=%0b, want stable access own=%0b addr=%h",
                                 cyc, bus.m_req, bus.owner, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata,
                                 bus.i_ready, bus.d_ready, cur, exp_addr);
                    end
                end
            end else begin
                checks++;
                if ({bus.m_req, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err} !== 5'b0) begin
                    errors++;
                    $display("FAIL rnd_after cyc=%0d: got mreq=%0b ir=%0b ie=%0b dr=%0b de=%0b, want all 0",
                             cyc, bus.m_req, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err);
                end
                phase = 0;
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, want completion");
        $fatal(1, "time limit");
    end

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_inst_read();
        test_write_be();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        test_hold_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port data memory between the core's instruction-fetch port (requester 0) and its load/store port (requester 1).
- Each access is sequenced as a registered request/acknowledge transaction toward a variable-latency memory.
- Arbitration is round-robin. Memory writes go out with byte enables.
- A watchdog aborts accesses the memory never acknowledges and returns an error to the requester.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 16, WAIT cycles without m_ack before abort; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  one-cycle completion pulse for requester 0.
- i_err  out  1  qualifies i_ready; 1 means the access timed out.
- i_rdata  out  DATA_W  fetched word; valid while i_ready=1 and held afterwards.
- d_req  in  1  data access request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse for requester 1.
- d_err  out  1  qualifies d_ready; 1 means timeout.
- d_rdata  out  DATA_W  load data; updated only on reads.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write strobe, registered.
- m_be  out  4  memory byte enables, registered.
- m_addr  out  ADDR_W  memory address, registered.
- m_wdata  out  DATA_W  memory write data, registered.
- m_ack  in  1  memory completion; sampled only while m_req=1.
- m_rdata  in  DATA_W  memory read data; valid when m_ack=1.
- owner  out  1  current or last granted requester (0 = inst, 1 = data).

Behaviour:
- Reset values: all outputs 0, i_rdata/d_rdata 0, state IDLE, last_grant=1 so inst wins the first tie, watchdog counter 0.
- Reset is asynchronous and may assert in any state; an in-flight access is dropped with no ready pulse.
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - On a grant, latch addr/we/be/wdata into the m_* registers (inst port drives we=0, be=4'b1111, wdata=0), set owner and last_grant, clear the counter, set m_req=1, go to WAIT.
- WAIT:
  - m_* fields are stable while m_req=1.
  - m_ack=1: set m_req=0; if the access is a read, capture m_rdata into the owner's rdata register; set the owner's ready=1, err=0; go to DONE.
  - m_ack=0 and TIMEOUT≠0 and counter==TIMEOUT-1: set m_req=0; owner ready=1, err=1; rdata unchanged; go to DONE.
  - Otherwise: increment the counter and stay in WAIT.
- DONE:
  - ready/err are high for exactly this one cycle, then both drop to 0; go to IDLE.
  - The requests are ignored in this cycle.
  - A requester must drop req in the cycle after its ready; a req still high in IDLE is a new access.
- Latency: req sampled in IDLE at cycle 0 gives m_req=1 at cycle 1. m_ack sampled at cycle k≥1 gives ready at cycle k+1 and IDLE at cycle k+2. Minimum turnaround is 3 cycles per access.
- Fairness: with both requesters continuously requesting, grants alternate inst, data, inst, …; neither can starve.
- m_ack while m_req=0 is ignored.
- A write never modifies d_rdata.
- d_be=0 still issues an access, with m_be=0.

Test Plan:
- Reset, then i_req=1, i_addr=0x100; memory acks in the first WAIT cycle with m_rdata=0xE3A00001 -> m_req=1, m_addr=0x100, m_we=0 at cycle 1; i_ready=1, i_rdata=0xE3A00001, i_err=0 at cycle 2; state IDLE at cycle 3.
- d_req, d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0x12345678, ack after 3 wait cycles -> m_wdata=0x12345678, m_be=0011 stable through WAIT; d_ready pulses once; d_rdata unchanged.
- i_req and d_req asserted together from reset, both held and re-requested -> grant order inst, data, inst, data; owner toggles each access.
- TIMEOUT=16, m_ack never asserted -> m_req high for exactly 16 cycles, then d_ready=1 with d_err=1 for one cycle; next access completes normally with err=0.
- reset pulsed mid-WAIT -> m_req=0 immediately (asynchronous), no ready pulse; after release, i_req wins a simultaneous tie.
- req held high through DONE and dropped afterwards -> no duplicate access; held into IDLE -> exactly one new access issued.
